// File: rtl/xyz_to_vonkries_gain.sv
// Von Kries gains G_c = REF_c / SRC_c from an XYZ white point (Q16.16).
// One restoring divider shared over X, Y, Z; gains saturate at GAIN_MAX.
//
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset
//   xyz_in      source white X=[31:0] Y=[63:32] Z=[95:64], unsigned Q16.16
//   xyz_valid   one-cycle strobe, xyz_in valid
//   gain_out    gains Gx=[31:0] Gy=[63:32] Gz=[95:64], unsigned Q16.16
//   gain_valid  one-cycle pulse, gain_out updated
//   busy        high from capture through the DONE cycle
//   overrun     one-cycle pulse, xyz_valid dropped while busy
module xyz_to_vonkries_gain #(
  parameter int          FRAC_BITS = 16,
  parameter logic [31:0] REF_X     = 32'h0000F352,
  parameter logic [31:0] REF_Y     = 32'h00010000,
  parameter logic [31:0] REF_Z     = 32'h000116BF,
  parameter logic [31:0] GAIN_MAX  = 32'h00040000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [95:0] xyz_in,
  input  logic        xyz_valid,
  output logic [95:0] gain_out,
  output logic        gain_valid,
  output logic        busy,
  output logic        overrun
);

  localparam logic [31:0] UNITY = 32'h00010000;

  typedef enum logic [2:0] {
    IDLE, LOAD, DIV, STORE, DONE
  } state_t;

  state_t      state, state_nx;
  logic [95:0] src;
  logic [95:0] stage;
  logic [1:0]  ch;
  logic [47:0] dvd;
  logic [31:0] dvs;
  logic [32:0] rem;
  logic [47:0] quo;
  logic [5:0]  cnt;

  logic [31:0] ref_c;
  logic [31:0] src_c;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] res;

  always_comb begin
    ref_c = REF_X;
    src_c = src[31:0];
    unique case (ch)
      2'd1: begin
        ref_c = REF_Y;
        src_c = src[63:32];
      end
      2'd2: begin
        ref_c = REF_Z;
        src_c = src[95:64];
      end
      default: ;
    endcase
  end

  // rem < divisor always holds, so bit 32 is only ever needed after the shift
  assign rem_sh = {rem[31:0], dvd[cnt]};
  assign ge     = rem_sh >= {1'b0, dvs};

  // zero divisor bypasses the (meaningless) quotient
  always_comb begin
    res = quo[31:0];
    if (dvs == '0 || quo[47:32] != '0 || quo[31:0] > GAIN_MAX)
      res = GAIN_MAX;
  end

  assign busy    = (state != IDLE);
  assign overrun = xyz_valid && busy;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (xyz_valid) state_nx = LOAD;
      LOAD:  state_nx = DIV;
      DIV:   if (cnt == '0) state_nx = STORE;
      STORE: state_nx = (ch == 2'd2) ? DONE : LOAD;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      src        <= '0;
      stage      <= '0;
      ch         <= '0;
      dvd        <= '0;
      dvs        <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      gain_out   <= {3{UNITY}};
      gain_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      gain_valid <= 1'b0;
      unique case (state)
        IDLE: if (xyz_valid) begin
          src <= xyz_in;
          ch  <= '0;
        end
        LOAD: begin
          dvd <= {ref_c, {FRAC_BITS{1'b0}}};
          dvs <= src_c;
          rem <= '0;
          quo <= '0;
          cnt <= 6'd47;
        end
        DIV: begin
          if (ge) begin
            rem      <= rem_sh - {1'b0, dvs};
            quo[cnt] <= 1'b1;
          end else begin
            rem <= rem_sh;
          end
          cnt <= cnt - 6'd1;
        end
        STORE: begin
          unique case (ch)
            2'd0:    stage[31:0]  <= res;
            2'd1:    stage[63:32] <= res;
            default: stage[95:64] <= res;
          endcase
          if (ch != 2'd2) ch <= ch + 2'd1;
        end
        DONE: begin
          gain_out   <= stage;
          gain_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
